// File: rtl/vdiv_arbiter_pkg.sv
// Shared types and constants for the FP16 divider arbiter.
package vdiv_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } vdiv_arb_state_t;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after `last`,
// wrapping around. Output is one-hot, or zero when nothing is requesting.
module rr_arbiter #(
    parameter int N = 4,
    localparam int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  gnt
);

    logic found;

    // Offset k walks the priority order; the first requesting slot wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == (int'(last) + 1 + k) % N)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vdiv_arbiter.sv
// Shares one FP16 divider among NREQ requesters with round-robin arbitration,
// a watchdog on the divider's done, and a backpressured tagged response.
//
// state | meaning
// IDLE  | arbitrate; req_ready = grant, accept latches operands
// BUSY  | div_en high, wait for div_done or watchdog expiry
// RESP  | rsp_valid high, hold response until rsp_ready
module vdiv_arbiter
    import vdiv_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0][15:0] req_a,
    input  logic [NREQ-1:0][15:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  div_en,
    output logic [15:0]           div_a,
    output logic [15:0]           div_b,
    input  logic                  div_done,
    input  logic [15:0]           div_result,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           rsp_result,
    output logic                  rsp_err,
    input  logic                  rsp_ready
);

    localparam int LW  = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

    vdiv_arb_state_t state;
    logic [LW-1:0]   last_q;
    logic [WDW-1:0]  wdog;
    logic [NREQ-1:0] grant;
    logic [LW-1:0]   gnt_idx;
    logic [15:0]     a_sel;
    logic [15:0]     b_sel;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req  (req_valid),
        .last (last_q),
        .gnt  (grant)
    );

    assign req_ready = (state == IDLE) ? grant : '0;

    // Grant is one-hot, so OR-ing the selected lanes acts as a mux.
    always_comb begin
        gnt_idx = '0;
        a_sel   = '0;
        b_sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_idx = gnt_idx | LW'(i);
                a_sel   = a_sel | req_a[i];
                b_sel   = b_sel | req_b[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            last_q     <= LW'(NREQ - 1);
            wdog       <= '0;
            div_en     <= 1'b0;
            div_a      <= '0;
            div_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        div_a  <= a_sel;
                        div_b  <= b_sel;
                        rsp_id <= IDW'(gnt_idx);
                        last_q <= gnt_idx;
                        wdog   <= '0;
                        div_en <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (wdog != '1) begin
                        wdog <= wdog + 1'b1;
                    end
                    // done has priority over a coincident watchdog expiry
                    if (div_done) begin
                        rsp_result <= div_result;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        div_en     <= 1'b0;
                        state      <= RESP;
                    end else if (wdog == WDOG_LAST) begin
                        rsp_result <= FP16_QNAN;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        div_en     <= 1'b0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vdiv_arbiter.sv
// Self-checking bench for vdiv_arbiter with a programmable-latency divider stub.
module tb_vdiv_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TMO  = 8;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0][15:0] req_a;
    logic [NREQ-1:0][15:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  div_en;
    logic [15:0]           div_a;
    logic [15:0]           div_b;
    logic                  div_done;
    logic [15:0]           div_result;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [15:0]           rsp_result;
    logic                  rsp_err;
    logic                  rsp_ready;

    int checks   = 0;
    int failures = 0;
    int last_m   = NREQ - 1;
    int stub_lat = 1;
    int stub_cnt = 0;

    always #5 CLK = ~CLK;

    vdiv_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TMO)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .div_en     (div_en),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_done   (div_done),
        .div_result (div_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready)
    );

    // Known FP16 quotients for the directed cases; any other pair yields a
    // distinctive token so pass-through of arbitrary values is still visible.
    function automatic logic [15:0] fp16_div(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3C00_4000: return 16'h3800;
            32'h4000_3C00: return 16'h4000;
            32'h7C00_7C00: return 16'h7E00;
            32'h3C00_0000: return 16'h7C00;
            default:       return a ^ {b[7:0], b[15:8]} ^ 16'h1234;
        endcase
    endfunction

    // Divider stub: done rises stub_lat cycles after en is first seen; 0 = never.
    always @(posedge CLK) begin
        if (RST || !div_en) begin
            stub_cnt   <= 0;
            div_done   <= 1'b0;
            div_result <= 16'hDEAD;
        end else if (!div_done && stub_lat > 0) begin
            if (stub_cnt == stub_lat - 1) begin
                div_done   <= 1'b1;
                div_result <= fp16_div(div_a, div_b);
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i == (last + k) % NREQ && m[i]) return i;
            end
        end
        return -1;
    endfunction

    task automatic do_reset();
        RST       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST    = 1'b0;
        last_m = NREQ - 1;
    endtask

    // Called at a negedge with inputs already driven; returns at the negedge
    // of the first IDLE cycle after the response is consumed.
    task automatic run_op(input int exp_id, input int hold, input bit scramble);
        int          n;
        int          exp_n;
        bit          tmo;
        logic [15:0] ea, eb, er;
        logic [NREQ-1:0] eg;
        eg    = NREQ'(1 << exp_id);
        ea    = req_a[exp_id[IDW-1:0]];
        eb    = req_b[exp_id[IDW-1:0]];
        tmo   = (stub_lat == 0) || (stub_lat >= TMO);
        exp_n = tmo ? TMO + 1 : stub_lat + 2;
        er    = tmo ? 16'h7E00 : fp16_div(ea, eb);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== eg) begin
            failures++;
            $display("FAIL grant: req_ready=%b expected=%b", req_ready, eg);
        end
        last_m = exp_id;
        @(negedge CLK);
        n = 1;
        if (scramble) begin
            for (int i = 0; i < NREQ; i++) begin
                req_a[i] = 16'($urandom);
                req_b[i] = 16'($urandom);
            end
        end
        while (!rsp_valid && n < 40) begin
            checks++;
            if (div_en !== 1'b1 || div_a !== ea || div_b !== eb || req_ready !== '0) begin
                failures++;
                $display("FAIL busy: cyc=%0d div_en=%b a=%h b=%h rdy=%b expected en=1 a=%h b=%h rdy=0",
                         n, div_en, div_a, div_b, req_ready, ea, eb);
            end
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n !== exp_n) begin
            failures++;
            $display("FAIL latency: rsp_valid at cycle %0d expected %0d", n, exp_n);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== exp_id[IDW-1:0] || rsp_result !== er ||
            rsp_err !== tmo || div_en !== 1'b0) begin
            failures++;
            $display("FAIL response: valid=%b id=%0d res=%h err=%b en=%b expected 1 %0d %h %b 0",
                     rsp_valid, rsp_id, rsp_result, rsp_err, div_en, exp_id, er, tmo);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id[IDW-1:0] || rsp_result !== er ||
                rsp_err !== tmo || div_en !== 1'b0 || req_ready !== '0) begin
                failures++;
                $display("FAIL hold: valid=%b id=%0d res=%h err=%b en=%b rdy=%b expected 1 %0d %h %b 0 0",
                         rsp_valid, rsp_id, rsp_result, rsp_err, div_en, req_ready, exp_id, er, tmo);
            end
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rsp_release: rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (div_en !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_id !== '0 ||
            rsp_result !== '0 || div_a !== '0 || div_b !== '0 || req_ready !== '0) begin
            failures++;
            $display("FAIL %s: en=%b valid=%b err=%b id=%0d res=%h a=%h b=%h rdy=%b expected all 0",
                     tag, div_en, rsp_valid, rsp_err, rsp_id, rsp_result, div_a, div_b, req_ready);
        end
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        @(negedge CLK);
        @(negedge CLK);
        check_reset_outputs("reset_state");
        RST    = 1'b0;
        last_m = NREQ - 1;
        @(negedge CLK);
        check_reset_outputs("idle_no_req");
    endtask

    task automatic test_single();
        do_reset();
        req_a[0]  = 16'h3C00;
        req_b[0]  = 16'h4000;
        req_valid = 4'b0001;
        stub_lat  = 3;
        run_op(0, 0, 1'b0);
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i] = 16'h4000;
            req_b[i] = 16'h3C00;
        end
        req_valid = 4'b1111;
        stub_lat  = 2;
        for (int i = 0; i < 5; i++) begin
            run_op(order[i], 0, 1'b0);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        req_valid = 4'b1010;
        req_a[1]  = 16'h1111;
        req_b[1]  = 16'h2222;
        req_a[3]  = 16'h3333;
        req_b[3]  = 16'h4444;
        stub_lat  = 4;
        run_op(rr_pick(req_valid, last_m), 5, 1'b0);
        run_op(rr_pick(req_valid, last_m), 5, 1'b0);
        req_valid = '0;
    endtask

    task automatic test_timeout();
        int lats [3] = '{0, TMO - 1, TMO};
        req_a[1]  = 16'h3C00;
        req_b[1]  = 16'h4000;
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'b0010;
            stub_lat  = lats[i];
            run_op(1, 1, 1'b0);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0110;
        req_a[1]  = 16'h5555;
        req_b[1]  = 16'h6666;
        req_a[2]  = 16'h7777;
        req_b[2]  = 16'h0888;
        stub_lat  = 0;
        #1;
        checks++;
        if (req_ready === '0) begin
            failures++;
            $display("FAIL mid_grant: req_ready=%b expected nonzero", req_ready);
        end
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        req_valid = '0;
        RST       = 1'b1;
        @(negedge CLK);
        check_reset_outputs("reset_mid_busy");
        RST    = 1'b0;
        last_m = NREQ - 1;
        for (int i = 0; i < TMO + 3; i++) begin
            @(negedge CLK);
            checks++;
            if (rsp_valid !== 1'b0 || div_en !== 1'b0) begin
                failures++;
                $display("FAIL aborted_rsp: rsp_valid=%b div_en=%b expected 0 0", rsp_valid, div_en);
            end
        end
        req_valid = 4'b1111;
        stub_lat  = 1;
        run_op(0, 0, 1'b0);
        req_valid = '0;
    endtask

    task automatic test_pass_through();
        do_reset();
        req_a[2]  = 16'h7C00;
        req_b[2]  = 16'h7C00;
        req_a[3]  = 16'h3C00;
        req_b[3]  = 16'h0000;
        req_valid = 4'b1100;
        stub_lat  = 5;
        run_op(rr_pick(req_valid, last_m), 0, 1'b0);
        run_op(rr_pick(req_valid, last_m), 0, 1'b0);
        req_valid = '0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_a[i] = 16'($urandom);
                req_b[i] = 16'($urandom);
            end
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            stub_lat  = $urandom_range(1, TMO + 2);
            run_op(rr_pick(req_valid, last_m), $urandom_range(0, 3), 1'b1);
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_pass_through();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
